// File: rtl/block_stream_emitter.sv
// Serialises begin/end commands into an ASCII keyword stream ("begin " / "end "),
// one character per handshake, while tracking the nesting depth of the emitted stream.
//
// state | meaning
// IDLE  | waiting for a command; cmd_ready high
// EMIT  | presenting keyword characters word[idx] to the downstream checker
module block_stream_emitter #(
    parameter int DEPTH_W   = 8,
    parameter int MAX_DEPTH = 255
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    input  logic               cmd_end,
    input  logic               cmd_upper,
    output logic               cmd_ready,
    output logic [7:0]         out_char,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DEPTH_W-1:0] depth,
    output logic               balanced,
    output logic               underflow,
    output logic               overflow
);

    typedef enum logic {IDLE, EMIT} state_t;

    localparam logic [DEPTH_W-1:0] MAX_D = DEPTH_W'(MAX_DEPTH);

    state_t             state, state_n;
    logic [2:0]         idx, idx_n;
    logic               op_end, op_end_n;
    logic               op_upper, op_upper_n;
    logic [DEPTH_W-1:0] depth_n;
    logic               underflow_n, overflow_n;
    logic [7:0]         char_n;
    logic               accept, hand, last;

    function automatic logic [7:0] kw_char(input logic e, input logic u, input logic [2:0] i);
        logic [7:0] c;
        if (e) begin
            case (i)
                3'd0:    c = 8'h65;
                3'd1:    c = 8'h6E;
                3'd2:    c = 8'h64;
                default: c = 8'h20;
            endcase
        end else begin
            case (i)
                3'd0:    c = 8'h62;
                3'd1:    c = 8'h65;
                3'd2:    c = 8'h67;
                3'd3:    c = 8'h69;
                3'd4:    c = 8'h6E;
                default: c = 8'h20;
            endcase
        end
        // only letters fold to upper case; the trailing space stays 0x20
        if (u && c != 8'h20) c = c - 8'h20;
        return c;
    endfunction

    assign accept   = (state == IDLE) && cmd_ready && cmd_valid;
    assign hand     = (state == EMIT) && out_valid && out_ready;
    assign last     = (idx == (op_end ? 3'd3 : 3'd5));
    assign balanced = (depth == '0) && !underflow;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            idx       <= 3'd0;
            op_end    <= 1'b0;
            op_upper  <= 1'b0;
            depth     <= '0;
            underflow <= 1'b0;
            overflow  <= 1'b0;
            cmd_ready <= 1'b0;
            out_valid <= 1'b0;
            out_char  <= 8'h00;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            op_end    <= op_end_n;
            op_upper  <= op_upper_n;
            depth     <= depth_n;
            underflow <= underflow_n;
            overflow  <= overflow_n;
            cmd_ready <= (state_n == IDLE);
            out_valid <= (state_n == EMIT);
            out_char  <= char_n;
        end
    end

    // depth moves at command accept, saturating at both ends with sticky flags
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        op_end_n    = op_end;
        op_upper_n  = op_upper;
        depth_n     = depth;
        underflow_n = underflow;
        overflow_n  = overflow;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_n    = EMIT;
                    idx_n      = 3'd0;
                    op_end_n   = cmd_end;
                    op_upper_n = cmd_upper;
                    if (cmd_end) begin
                        if (depth == '0) underflow_n = 1'b1;
                        else             depth_n     = depth - DEPTH_W'(1);
                    end else begin
                        if (depth >= MAX_D) overflow_n = 1'b1;
                        else                depth_n    = depth + DEPTH_W'(1);
                    end
                end
            end
            EMIT: begin
                if (hand) begin
                    if (last) state_n = IDLE;
                    else      idx_n   = idx + 3'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        char_n = 8'h00;
        if (state_n == EMIT) char_n = kw_char(op_end_n, op_upper_n, idx_n);
    end

endmodule

// File: tb/tb_block_stream_emitter.sv
// Scoreboard bench for block_stream_emitter: a keyword/depth model fills an expectation
// queue on every accepted command, and a monitor checks each handed-off character.
module tb_block_stream_emitter;

    localparam int DEPTH_W   = 8;
    localparam int MAX_DEPTH = 3;

    logic               clk = 1'b0;
    logic               reset = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_end = 1'b0;
    logic               cmd_upper = 1'b0;
    logic               cmd_ready;
    logic [7:0]         out_char;
    logic               out_valid;
    logic               out_ready = 1'b0;
    logic [DEPTH_W-1:0] depth;
    logic               balanced;
    logic               underflow;
    logic               overflow;

    block_stream_emitter #(.DEPTH_W(DEPTH_W), .MAX_DEPTH(MAX_DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_end(cmd_end), .cmd_upper(cmd_upper), .cmd_ready(cmd_ready),
        .out_char(out_char), .out_valid(out_valid), .out_ready(out_ready),
        .depth(depth), .balanced(balanced), .underflow(underflow), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] ch;
        bit         first;
        int         d;
        bit         uf;
        bit         of;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   m_depth = 0;
    bit   m_uf = 1'b0;
    bit   m_of = 1'b0;
    bit   pend = 1'b0;
    bit   pend_end = 1'b0;
    bit   pend_up = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_accept(input bit e, input bit u);
        string w;
        exp_t  x;
        w = e ? "end " : "begin ";
        if (e) begin
            if (m_depth == 0) m_uf = 1'b1;
            else              m_depth--;
        end else begin
            if (m_depth == MAX_DEPTH) m_of = 1'b1;
            else                      m_depth++;
        end
        for (int i = 0; i < w.len(); i++) begin
            x.ch = w[i];
            if (u && x.ch != 8'h20) x.ch = x.ch - 8'h20;
            x.first = (i == 0);
            x.d = m_depth;
            x.uf = m_uf;
            x.of = m_of;
            q.push_back(x);
        end
    endtask

    // drive at negedge, sample just before the following posedge
    task automatic cycle(input bit rst_v, input bit rdy);
        @(negedge clk);
        reset = rst_v;
        cmd_valid = pend;
        cmd_end = pend_end;
        cmd_upper = pend_up;
        out_ready = rdy;
        #4;
        if (reset && cmd_valid && cmd_ready) begin
            model_accept(pend_end, pend_up);
            pend = 1'b0;
        end
    endtask

    task automatic send(input bit e, input bit u);
        int n;
        pend = 1'b1;
        pend_end = e;
        pend_up = u;
        n = 0;
        while (pend && n < 50) begin
            cycle(1'b1, 1'b1);
            n++;
        end
        if (pend) begin
            check("cmd_accept_timeout", 0, 1);
            pend = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || pend) && n < 200) begin
            cycle(1'b1, 1'b1);
            n++;
        end
        check("drain_left", q.size(), 0);
    endtask

    task automatic do_reset();
        pend = 1'b0;
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        q.delete();
        m_depth = 0;
        m_uf = 1'b0;
        m_of = 1'b0;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_char", out_char, 0);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_depth", depth, 0);
        check("rst_balanced", balanced, 1);
        check("rst_underflow", underflow, 0);
        check("rst_overflow", overflow, 0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        check("post_rst_cmd_ready", cmd_ready, 1);
    endtask

    always @(negedge clk) begin
        #4;
        if (reset) begin
            checks++;
            if (cmd_ready && out_valid) begin
                errors++;
                $display("FAIL ready_valid_overlap: cmd_ready=1 out_valid=1 required not both at %0t", $time);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    check("unexpected_char", out_char, 0);
                    errors++;
                    $display("FAIL unexpected_char: got %0h with empty queue at %0t", out_char, $time);
                end else begin
                    exp_t x;
                    x = q.pop_front();
                    check("out_char", out_char, x.ch);
                    if (x.first) begin
                        check("depth", depth, x.d);
                        check("underflow", underflow, x.uf);
                        check("overflow", overflow, x.of);
                        check("balanced", balanced, (x.d == 0 && !x.uf) ? 1 : 0);
                    end
                end
            end
        end
    end

    initial begin
        do_reset();

        send(1'b0, 1'b0);
        drain();
        check("bal_after_begin", balanced, 0);
        send(1'b0, 1'b1);
        send(1'b1, 1'b0);
        drain();
        send(1'b1, 1'b0);
        drain();
        check("bal_after_begin_end", balanced, 1);
        send(1'b1, 1'b0);
        drain();
        check("uf_after_end_at_0", underflow, 1);
        send(1'b0, 1'b0);
        send(1'b1, 1'b0);
        drain();
        check("bal_sticky_uf", balanced, 0);

        // backpressure on the third character of "begin"
        do_reset();
        send(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 1'b0);
            check("stall_char", out_char, 8'h67);
            check("stall_valid", out_valid, 1);
        end
        drain();

        // overflow: four begins against MAX_DEPTH=3
        for (int i = 0; i < 4; i++) send(1'b0, i[0]);
        drain();
        check("overflow_set", overflow, 1);
        check("depth_sat", depth, MAX_DEPTH);

        for (int i = 0; i < 1500; i++) begin
            if (!pend && $urandom_range(0, 2) == 0) begin
                pend = 1'b1;
                pend_end = 1'($urandom_range(0, 1));
                pend_up = 1'($urandom_range(0, 1));
            end
            cycle(1'b1, $urandom_range(0, 3) != 0);
        end
        drain();

        // reset in the middle of a word
        do_reset();
        send(1'b0, 1'b0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b1);
        q.delete();
        m_depth = 0;
        m_uf = 1'b0;
        m_of = 1'b0;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_depth", depth, 0);
        check("midrst_flags", {underflow, overflow}, 0);
        cycle(1'b1, 1'b1);
        cycle(1'b1, 1'b1);
        check("midrst_cmd_ready", cmd_ready, 1);
        check("midrst_no_char", out_valid, 0);

        for (int i = 0; i < 1500; i++) begin
            if (!pend && $urandom_range(0, 1) == 0) begin
                pend = 1'b1;
                pend_end = 1'($urandom_range(0, 2) == 0);
                pend_up = 1'($urandom_range(0, 1));
            end
            cycle(1'b1, $urandom_range(0, 2) != 0);
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
